// File: rtl/moving_avg_filter.sv
// moving_avg_filter: sliding-window mean over 2^LOG2_DEPTH samples, running sum, optional prefill and outlier reject/re-seed
// sys_clk, sys_rst (sync, active-high), clear (sync flush); din_valid/din in; dout/dout_valid, window_full, rejected out
module moving_avg_filter #(
  parameter int DATA_W     = 13,
  parameter int LOG2_DEPTH = 3,
  parameter int PREFILL    = 0,
  parameter int REJECT_TH  = 0,
  parameter int REJECT_MAX = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              clear,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              window_full,
  output logic              rejected
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam logic [31:0] TH = REJECT_TH;
  localparam logic [3:0] REJ_LAST = 4'(REJECT_MAX - 1);
  localparam logic [LOG2_DEPTH:0] FILL_LAST = (LOG2_DEPTH + 1)'(DEPTH - 1);
  typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH:0] fill_cnt;
  logic [3:0] rej_cnt;
  logic [SUM_W-1:0] sum;
  logic p_valid, p_rej;
  logic [DATA_W-1:0] diff;
  logic outlier, seed, drop;
  // diff is taken against the registered dout, not the just-updated sum
  always_comb begin
    diff = din > dout ? din - dout : dout - din;
    outlier = REJECT_TH != 0 && state == RUN && 32'(diff) > TH;
    seed = din_valid && ((state == EMPTY && PREFILL != 0) || (outlier && rej_cnt == REJ_LAST));
    drop = din_valid && outlier && rej_cnt != REJ_LAST;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= EMPTY;
      wr_ptr <= '0;
      fill_cnt <= '0;
      rej_cnt <= '0;
      sum <= '0;
      p_valid <= 1'b0;
      p_rej <= 1'b0;
      dout <= '0;
      dout_valid <= 1'b0;
      window_full <= 1'b0;
      rejected <= 1'b0;
    end else begin
      p_valid <= din_valid;
      p_rej <= drop;
      dout_valid <= p_valid;
      rejected <= p_rej;
      window_full <= state == RUN;
      if (p_valid) dout <= sum[SUM_W-1:LOG2_DEPTH];
      if (seed) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= din;
        sum <= SUM_W'(din) << LOG2_DEPTH;
        wr_ptr <= '0;
        rej_cnt <= '0;
        state <= RUN;
      end else if (drop) begin
        rej_cnt <= rej_cnt + 1'b1;
      end else if (din_valid) begin
        mem[wr_ptr] <= din;
        sum <= sum + SUM_W'(din) - SUM_W'(mem[wr_ptr]);
        wr_ptr <= wr_ptr + 1'b1;
        rej_cnt <= '0;
        if (state != RUN) begin
          fill_cnt <= fill_cnt + 1'b1;
          state <= fill_cnt == FILL_LAST ? RUN : FILL;
        end
      end
    end
  end
endmodule

// File: tb/tb_moving_avg_filter.sv
// tb_moving_avg_filter: three filter configurations against a queue-based window model
module tb_moving_avg_filter;
  logic sys_clk = 1'b0, sys_rst = 1'b1, clear = 1'b0, din_valid = 1'b0;
  logic [12:0] din = '0;
  logic [12:0] dout_w [3];
  logic dv_w [3], wf_w [3], rej_w [3];
  int total = 0, bad = 0;
  int pf [3] = '{0, 1, 1};
  int th [3] = '{0, 0, 50};
  int rmax [3] = '{3, 3, 3};
  int win [3][$];
  int cnt [3], rejc [3], e_dout [3], e_dv [3], e_rej [3], e_wf [3];
  int p_has [3], p_mean [3], p_rej [3], p_full [3];
  int pv [3][$], prj [3][$], pwf [3][$];
  time pt [3][$];
  time ts [$];
  int base, n;
  always #5 sys_clk = ~sys_clk;
  moving_avg_filter d0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .clear(clear), .din_valid(din_valid), .din(din),
    .dout(dout_w[0]), .dout_valid(dv_w[0]), .window_full(wf_w[0]), .rejected(rej_w[0]));
  moving_avg_filter #(.PREFILL(1)) d1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .clear(clear), .din_valid(din_valid), .din(din),
    .dout(dout_w[1]), .dout_valid(dv_w[1]), .window_full(wf_w[1]), .rejected(rej_w[1]));
  moving_avg_filter #(.PREFILL(1), .REJECT_TH(50), .REJECT_MAX(3)) d2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .clear(clear),
    .din_valid(din_valid), .din(din), .dout(dout_w[2]), .dout_valid(dv_w[2]), .window_full(wf_w[2]), .rejected(rej_w[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int win_mean(input int k);
    int s = 0;
    for (int i = 0; i < win[k].size(); i++) s += win[k][i];
    return s / 8;
  endfunction
  task automatic seed_win(input int k, input int v);
    for (int i = 0; i < 8; i++) win[k][i] = v;
    cnt[k] = 8;
    rejc[k] = 0;
  endtask
  task automatic model_step(input int k);
    int nh, nr, diff, v;
    if (sys_rst || clear) begin
      win[k] = {};
      repeat (8) win[k].push_back(0);
      cnt[k] = 0; rejc[k] = 0; e_dout[k] = 0; e_dv[k] = 0; e_rej[k] = 0; e_wf[k] = 0; p_has[k] = 0;
      return;
    end
    nh = int'(din_valid);
    nr = 0;
    if (din_valid) begin
      v = int'(din);
      diff = v - e_dout[k];
      if (diff < 0) diff = -diff;
      if (cnt[k] < 8 && pf[k] != 0) seed_win(k, v);
      else if (cnt[k] >= 8 && th[k] != 0 && diff > th[k]) begin
        if (rejc[k] < rmax[k] - 1) begin
          rejc[k]++;
          nr = 1;
        end else seed_win(k, v);
      end else begin
        win[k].push_back(v);
        void'(win[k].pop_front());
        cnt[k]++;
        rejc[k] = 0;
      end
    end
    e_dv[k] = p_has[k];
    if (p_has[k] != 0) begin
      e_dout[k] = p_mean[k];
      e_wf[k] = p_full[k];
    end
    e_rej[k] = p_has[k] != 0 ? p_rej[k] : 0;
    p_has[k] = nh;
    p_mean[k] = win_mean(k);
    p_rej[k] = nr;
    p_full[k] = cnt[k] >= 8 ? 1 : 0;
  endtask
  task automatic tick;
    @(posedge sys_clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dv%0d", k), 32'(dv_w[k]), e_dv[k]);
      check($sformatf("dout%0d", k), 32'(dout_w[k]), e_dout[k]);
      check($sformatf("wf%0d", k), 32'(wf_w[k]), e_wf[k]);
      check($sformatf("rej%0d", k), 32'(rej_w[k]), e_rej[k]);
      if (dv_w[k]) begin
        pv[k].push_back(int'(dout_w[k]));
        prj[k].push_back(int'(rej_w[k]));
        pwf[k].push_back(int'(wf_w[k]));
        pt[k].push_back($time);
      end
    end
  endtask
  task automatic flush_logs;
    ts = {};
    for (int k = 0; k < 3; k++) begin
      pv[k] = {}; prj[k] = {}; pwf[k] = {}; pt[k] = {};
    end
  endtask
  task automatic do_reset;
    sys_rst = 1'b1;
    tick;
    tick;
    sys_rst = 1'b0;
    flush_logs;
  endtask
  task automatic put(input int v, input int gap);
    din = 13'(v);
    din_valid = 1'b1;
    ts.push_back($time);
    tick;
    din_valid = 1'b0;
    repeat (gap) tick;
  endtask
  initial begin
    int fill_exp [8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    int rej_dout [6] = '{400, 400, 400, 1000, 1000, 1005};
    int rej_flag [6] = '{0, 1, 1, 0, 0, 0};
    @(negedge sys_clk);
    do_reset;
    for (int k = 0; k < 3; k++) begin
      check("reset_dout", 32'(dout_w[k]), 0);
      check("reset_flags", {29'd0, dv_w[k], wf_w[k], rej_w[k]}, 0);
    end
    for (int i = 0; i < 8; i++) put(100, 0);
    repeat (3) tick;
    check("fill_pulses", pv[0].size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_dout%0d", i), pv[0][i], fill_exp[i]);
      check($sformatf("fill_lat%0d", i), 32'(pt[0][i] - ts[i]), 20);
    end
    check("fill_wf7", pwf[0][6], 0);
    check("fill_wf8", pwf[0][7], 1);
    do_reset;
    for (int i = 0; i < 16; i++) put(8191, $urandom_range(0, 5));
    repeat (3) tick;
    check("fs_pulses", pv[0].size(), 16);
    check("fs_dout8", pv[0][7], 8191);
    check("fs_dout16", pv[0][15], 8191);
    do_reset;
    put(400, 2);
    put(480, 2);
    check("pf_first", pv[1][0], 400);
    check("pf_first_wf", pwf[1][0], 1);
    check("pf_second", pv[1][1], 410);
    do_reset;
    put(400, 2);
    repeat (4) put(1000, 2);
    put(1040, 2);
    check("rej_pulses", pv[2].size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rej_dout%0d", i), pv[2][i], rej_dout[i]);
      check($sformatf("rej_flag%0d", i), prj[2][i], rej_flag[i]);
    end
    for (int m = 0; m < 2; m++) begin
      do_reset;
      repeat (5) put(200, 1);
      n = pv[0].size();
      din = 13'd999;
      din_valid = 1'b1;
      if (m == 0) clear = 1'b1; else sys_rst = 1'b1;
      tick;
      din_valid = 1'b0;
      clear = 1'b0;
      sys_rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("clr%0d_dout%0d", m, k), 32'(dout_w[k]), 0);
        check($sformatf("clr%0d_flags%0d", m, k), {29'd0, dv_w[k], wf_w[k], rej_w[k]}, 0);
      end
      tick;
      check($sformatf("clr%0d_nopulse", m), pv[0].size(), n);
      put(80, 2);
      check($sformatf("clr%0d_after", m), pv[0][pv[0].size() - 1], 10);
      check($sformatf("clr%0d_after_pf", m), pv[1][pv[1].size() - 1], 80);
    end
    do_reset;
    base = 2000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) base = $urandom_range(0, 8191);
      n = base + $urandom_range(0, 120) - 60;
      din = 13'(n < 0 ? 0 : n > 8191 ? 8191 : n);
      din_valid = $urandom_range(0, 2) != 0;
      clear = $urandom_range(0, 199) == 0;
      tick;
    end
    din_valid = 1'b0;
    clear = 1'b0;
    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

Parametrised sliding-window mean filter for ranging samples, for use between the distance-binning stage and the display/UART consumers. Generalises the fixed 13-bit, 8-deep filter: window width and depth are parameters, and the window sum is kept as a running total. Input and output are valid-qualified rather than free-running. The block adds optional first-sample prefill and outlier rejection with automatic re-seed on a genuine step change.

## Interface
- DATA_W, 13: sample width, unsigned.
- LOG2_DEPTH, 3: log2 of window depth. DEPTH = 2^LOG2_DEPTH. Legal range 1..6.
- PREFILL, 0: 1 means the first accepted sample after reset or clear seeds every window entry.
- REJECT_TH, 0: outlier threshold in LSBs. 0 disables rejection.
- REJECT_MAX, 3: number of consecutive outliers that forces a re-seed. Legal range 1..15.

- sys_clk  in  1  clock; all logic on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush. Same effect as sys_rst on the filter state.
- din_valid  in  1  sample strobe, one cycle per sample, arbitrary gaps allowed.
- din  in  DATA_W  sample value.
- dout  out  DATA_W  window mean, registered.
- dout_valid  out  1  one-cycle pulse per processed sample.
- window_full  out  1  high once DEPTH samples have entered the window since reset or clear.
- rejected  out  1  pulses together with dout_valid when the sample was discarded as an outlier.

## Operation
- Storage:
  - DEPTH x DATA_W register array with a circular write pointer wr_ptr (LOG2_DEPTH bits, wraps DEPTH-1 to 0).
  - sum is DATA_W+LOG2_DEPTH bits wide, so it cannot overflow.
- Accepted sample: sum <= sum + din - buf[wr_ptr]; buf[wr_ptr] <= din; wr_ptr++.
- Output: dout = sum >> LOG2_DEPTH, truncated (floor), no rounding.
- States:
  - EMPTY: after reset or clear.
  - FILL: reached from EMPTY on the first accepted sample when PREFILL=0. fill_cnt counts accepted samples; at fill_cnt = DEPTH go to RUN and set window_full.
  - RUN: the steady state.
- EMPTY with PREFILL=0:
  - Entries read as 0, so early outputs equal the zero-padded mean.
- EMPTY with PREFILL=1:
  - The first sample writes every entry; sum <= din << LOG2_DEPTH; wr_ptr <= 0.
  - Go straight to RUN with window_full=1.
- Outlier rejection (active only in RUN, and only when REJECT_TH != 0):
  - diff = |din - dout|, using the current registered dout.
  - diff <= REJECT_TH: accept normally; rej_cnt <= 0.
  - diff > REJECT_TH and rej_cnt < REJECT_MAX-1: discard the sample (buf, sum and wr_ptr unchanged); rej_cnt++. dout_valid still pulses with dout unchanged, and rejected=1.
  - diff > REJECT_TH and rej_cnt = REJECT_MAX-1: re-seed exactly as PREFILL does (all entries = din, sum = din << LOG2_DEPTH); rej_cnt <= 0; rejected=0.
- Rejection is never applied in EMPTY or FILL.
- sys_rst or clear:
  - buf and sum go to 0; wr_ptr, fill_cnt and rej_cnt go to 0; state goes to EMPTY.
  - dout, dout_valid, window_full and rejected go to 0.
- Simultaneous events: clear together with din_valid means clear wins and the sample is dropped with no dout_valid. sys_rst overrides everything.

## Timing
- Reset values: dout=0, dout_valid=0, window_full=0, rejected=0.
- Latency:
  - A din_valid sampled at edge E updates sum at E.
  - dout, dout_valid and rejected update at E+1.
  - dout_valid is therefore high in the cycle after E+1, two cycles after din is presented.
- Back-to-back din_valid is supported at full rate; every strobe yields exactly one dout_valid.
- window_full updates at E+1 together with the dout that first reflects DEPTH samples. It stays high until sys_rst or clear.
- dout holds its value between pulses.
- No backpressure; the consumer must take dout while dout_valid is high.

## Test plan
- Zero-padded fill: defaults; eight samples of 100 in consecutive cycles.
  - Required dout pulses: 12, 25, 37, 50, 62, 75, 87, 100.
  - window_full rises with the eighth pulse.
  - Each pulse arrives 2 cycles after its strobe.
- Full scale and wrap: sixteen samples of 8191 with random 0-5 cycle gaps.
  - dout settles at 8191; no overflow; sixteen pulses total.
  - wr_ptr wraps twice, so the ninth sample evicts the first.
- Prefill: PREFILL=1; first sample 400.
  - First dout = 400 with window_full=1.
  - Next sample 480 gives (3200-400+480)>>3 = 410.
- Rejection and re-seed: PREFILL=1, REJECT_TH=50, REJECT_MAX=3; seed 400, then 1000, 1000, 1000, then 1000.
  - Outputs: 400; 400 with rejected=1; 400 with rejected=1; 1000 with rejected=0; 1000.
  - A sample of 1040 after that is accepted: (8000-1000+1040)>>3 = 1005.
- Clear mid-stream: after five samples of 200, assert clear in the same cycle as a sample of 999.
  - No dout_valid for that sample; all outputs read 0 the cycle after.
  - The next sample of 80 gives dout 10.
  - Repeat the sequence using sys_rst instead of clear; the results must be identical.
